// File: rtl/cpld_pterm_pkg.sv
// Shared types and parameter limits for the product-term qualifier.
package cpld_pterm_pkg;

  typedef enum logic [1:0] {
    S_LO      = 2'd0,
    S_LO_QUAL = 2'd1,
    S_HI      = 2'd2,
    S_HI_QUAL = 2'd3
  } state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int FILT_LEN_MIN    = 1;

  function automatic bit params_legal(input int sync_stages, input int filt_len);
    return (sync_stages >= SYNC_STAGES_MIN) && (sync_stages <= SYNC_STAGES_MAX) &&
           (filt_len >= FILT_LEN_MIN);
  endfunction

endpackage

// File: rtl/cpld_sync_chain.sv
// Multi-flop synchroniser bringing the asynchronous product term into the CLK domain.
module cpld_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // shift the raw input one stage deeper each edge
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // chain flops, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!rn) begin
      sync_q <= {STAGES{1'b0}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cpld_pterm_qualifier.sv
// Synchronises and glitch-filters an AND4 product term, emitting a registered level,
// edge pulses and a wrapping count of qualified rising edges with sticky overflow.
module cpld_pterm_qualifier
  import cpld_pterm_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             PT,
  input  logic             CE,
  input  logic             CLR,
  output logic             Q0,
  output logic             RISE,
  output logic             FALL,
  output logic [CNT_W-1:0] CNT,
  output logic             OVF
);

  localparam int FCNT_W = $clog2(FILT_LEN + 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_LEN - 1);
  localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);
  localparam logic [FCNT_W-1:0] FCNT_ZERO = FCNT_W'(0);

  if (!params_legal(SYNC_STAGES, FILT_LEN)) begin : g_bad_params
    $error("cpld_pterm_qualifier: SYNC_STAGES or FILT_LEN out of range");
  end

  logic             ps;
  state_e           state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic             q0_q, q0_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  cpld_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (CLK),
    .rn  (RN),
    .d   (PT),
    .q   (ps)
  );

  // qualification FSM: a new level must be seen on FILT_LEN consecutive enabled cycles
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    q0_d    = q0_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (CE) begin
      case (state_q)
        S_LO: begin
          if (!ps) begin
            fcnt_d = FCNT_ZERO;
          end else if (FILT_LEN == 1) begin
            state_d = S_HI;
            q0_d    = 1'b1;
            rise_d  = 1'b1;
            fcnt_d  = FCNT_ZERO;
          end else begin
            state_d = S_LO_QUAL;
            fcnt_d  = FCNT_ONE;
          end
        end
        S_LO_QUAL: begin
          if (!ps) begin
            state_d = S_LO;
            fcnt_d  = FCNT_ZERO;
          end else if (fcnt_q == FCNT_LAST) begin
            state_d = S_HI;
            q0_d    = 1'b1;
            rise_d  = 1'b1;
            fcnt_d  = FCNT_ZERO;
          end else begin
            fcnt_d = fcnt_q + FCNT_ONE;
          end
        end
        S_HI: begin
          if (ps) begin
            fcnt_d = FCNT_ZERO;
          end else if (FILT_LEN == 1) begin
            state_d = S_LO;
            q0_d    = 1'b0;
            fall_d  = 1'b1;
            fcnt_d  = FCNT_ZERO;
          end else begin
            state_d = S_HI_QUAL;
            fcnt_d  = FCNT_ONE;
          end
        end
        S_HI_QUAL: begin
          if (ps) begin
            state_d = S_HI;
            fcnt_d  = FCNT_ZERO;
          end else if (fcnt_q == FCNT_LAST) begin
            state_d = S_LO;
            q0_d    = 1'b0;
            fall_d  = 1'b1;
            fcnt_d  = FCNT_ZERO;
          end else begin
            fcnt_d = fcnt_q + FCNT_ONE;
          end
        end
        default: begin
          state_d = S_LO;
          fcnt_d  = FCNT_ZERO;
          q0_d    = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
    end
  end

  // event counter: CLR wins over a coincident rise, wrap sets the sticky overflow
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (CLR) begin
      cnt_d = {CNT_W{1'b0}};
      ovf_d = 1'b0;
    end else if (rise_d) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == {CNT_W{1'b1}}) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // all state and outputs registered, synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q <= S_LO;
      fcnt_q  <= FCNT_ZERO;
      q0_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      q0_q    <= q0_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Q0   = q0_q;
  assign RISE = rise_q;
  assign FALL = fall_q;
  assign CNT  = cnt_q;
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_cpld_pterm_qualifier.sv
// Directed bench for cpld_pterm_qualifier with SYNC_STAGES=2, FILT_LEN=4, CNT_W=8.
module tb_cpld_pterm_qualifier;

  logic       CLK;
  logic       RN;
  logic       PT;
  logic       CE;
  logic       CLR;
  logic       Q0;
  logic       RISE;
  logic       FALL;
  logic [7:0] CNT;
  logic       OVF;

  int total = 0;
  int bad   = 0;
  logic rise_seen;
  logic fall_seen;

  cpld_pterm_qualifier #(.SYNC_STAGES(2), .FILT_LEN(4), .CNT_W(8)) dut (
    .CLK  (CLK),
    .RN   (RN),
    .PT   (PT),
    .CE   (CE),
    .CLR  (CLR),
    .Q0   (Q0),
    .RISE (RISE),
    .FALL (FALL),
    .CNT  (CNT),
    .OVF  (OVF)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // advance n edges; inputs and outputs are touched 1ns after each rising edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      rise_seen = rise_seen | RISE;
      fall_seen = fall_seen | FALL;
    end
  endtask

  task automatic clr_seen();
    rise_seen = 1'b0;
    fall_seen = 1'b0;
  endtask

  initial begin
    RN = 1'b0; PT = 1'b1; CE = 1'b1; CLR = 1'b0;
    clr_seen();

    // 1: reset with PT held high, then rise six edges after release
    tick(2);
    chk("rst_q0", {31'd0, Q0}, 32'd0);
    chk("rst_rise", {31'd0, RISE}, 32'd0);
    chk("rst_fall", {31'd0, FALL}, 32'd0);
    chk("rst_cnt", {24'd0, CNT}, 32'd0);
    chk("rst_ovf", {31'd0, OVF}, 32'd0);
    RN = 1'b1;
    tick(5);
    chk("t1_q0_early", {31'd0, Q0}, 32'd0);
    chk("t1_rise_early", {31'd0, rise_seen}, 32'd0);
    tick(1);
    chk("t1_q0", {31'd0, Q0}, 32'd1);
    chk("t1_rise", {31'd0, RISE}, 32'd1);
    chk("t1_cnt", {24'd0, CNT}, 32'd1);
    tick(1);
    chk("t1_rise_once", {31'd0, RISE}, 32'd0);

    // 2: fall path, CNT unchanged; then another rise
    clr_seen();
    PT = 1'b0;
    tick(5);
    chk("t2_q0_hold", {31'd0, Q0}, 32'd1);
    tick(1);
    chk("t2_q0_fall", {31'd0, Q0}, 32'd0);
    chk("t2_fall", {31'd0, FALL}, 32'd1);
    chk("t2_cnt_same", {24'd0, CNT}, 32'd1);
    tick(1);
    chk("t2_fall_once", {31'd0, FALL}, 32'd0);
    chk("t2_no_rise", {31'd0, rise_seen}, 32'd0);
    PT = 1'b1;
    tick(6);
    chk("t2_rise", {31'd0, RISE}, 32'd1);
    chk("t2_cnt2", {24'd0, CNT}, 32'd2);
    PT = 1'b0;
    tick(8);
    chk("t2_back_lo", {31'd0, Q0}, 32'd0);

    // 3: 3-cycle glitch rejected, 4-cycle pulse accepted
    CLR = 1'b1; tick(1); CLR = 1'b0;
    chk("t3_clr", {24'd0, CNT}, 32'd0);
    clr_seen();
    PT = 1'b1; tick(3); PT = 1'b0; tick(10);
    chk("t3_glitch_q0", {31'd0, Q0}, 32'd0);
    chk("t3_glitch_rise", {31'd0, rise_seen}, 32'd0);
    chk("t3_glitch_cnt", {24'd0, CNT}, 32'd0);
    clr_seen();
    PT = 1'b1; tick(4); PT = 1'b0; tick(2);
    chk("t3_four_q0", {31'd0, Q0}, 32'd1);
    chk("t3_four_rise", {31'd0, rise_seen}, 32'd1);
    chk("t3_four_cnt", {24'd0, CNT}, 32'd1);
    tick(8);
    chk("t3_four_fall", {31'd0, fall_seen}, 32'd1);

    // 4: wrap to zero with sticky overflow, cleared by CLR
    CLR = 1'b1; tick(1); CLR = 1'b0;
    for (int p = 0; p < 255; p++) begin
      PT = 1'b1; tick(6);
      PT = 1'b0; tick(6);
    end
    chk("t4_cnt255", {24'd0, CNT}, 32'd255);
    chk("t4_ovf0", {31'd0, OVF}, 32'd0);
    PT = 1'b1; tick(6); PT = 1'b0; tick(6);
    chk("t4_wrap_cnt", {24'd0, CNT}, 32'd0);
    chk("t4_wrap_ovf", {31'd0, OVF}, 32'd1);
    PT = 1'b1; tick(6); PT = 1'b0; tick(6);
    chk("t4_sticky_cnt", {24'd0, CNT}, 32'd1);
    chk("t4_sticky_ovf", {31'd0, OVF}, 32'd1);
    CLR = 1'b1; tick(1); CLR = 1'b0;
    chk("t4_clr_ovf", {31'd0, OVF}, 32'd0);
    chk("t4_clr_cnt", {24'd0, CNT}, 32'd0);

    // 5: CLR coincident with RISE
    PT = 1'b1; tick(6); PT = 1'b0; tick(6);
    chk("t5_pre_cnt", {24'd0, CNT}, 32'd1);
    PT = 1'b1; tick(5);
    CLR = 1'b1; tick(1); CLR = 1'b0;
    chk("t5_rise", {31'd0, RISE}, 32'd1);
    chk("t5_cnt", {24'd0, CNT}, 32'd0);
    PT = 1'b0; tick(8);

    // 6: CE hold mid-qualification, then reset discarding progress
    clr_seen();
    PT = 1'b1; tick(4);
    CE = 1'b0; tick(5);
    chk("t6_ce_hold_q0", {31'd0, Q0}, 32'd0);
    chk("t6_ce_hold_rise", {31'd0, rise_seen}, 32'd0);
    CE = 1'b1; tick(1);
    chk("t6_ce_one_more", {31'd0, Q0}, 32'd0);
    tick(1);
    chk("t6_ce_q0", {31'd0, Q0}, 32'd1);
    chk("t6_ce_rise", {31'd0, RISE}, 32'd1);
    PT = 1'b0; tick(8);
    chk("t6_lo_again", {31'd0, Q0}, 32'd0);
    clr_seen();
    PT = 1'b1; tick(4);
    RN = 1'b0; tick(1);
    chk("t6_rn_q0", {31'd0, Q0}, 32'd0);
    chk("t6_rn_cnt", {24'd0, CNT}, 32'd0);
    RN = 1'b1; tick(5);
    chk("t6_rn_no_rise", {31'd0, rise_seen}, 32'd0);
    chk("t6_rn_q0_lo", {31'd0, Q0}, 32'd0);
    tick(1);
    chk("t6_rn_requal", {31'd0, Q0}, 32'd1);
    chk("t6_rn_cnt1", {24'd0, CNT}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
